ssid_alloc_ctrl: RTL and testbench
==================================

SSID_ALLOC_CTRL -- requirements
Module: ssid_alloc_ctrl

Interface
REQ-001 SHALL have parameter STORE_SET_COUNT, default 64, the number of store sets in the SST.
REQ-002 SHALL have parameter SSID_WIDTH, default $clog2(STORE_SET_COUNT), the SSID width.
REQ-003 SHALL have parameter SSIT_INDEX_WIDTH, default 10, the SSIT index width.
REQ-004 SHALL have parameter FIFO_DEPTH, default 4, the number of violation events buffered.
REQ-005 SHALL have these ports: CLK in 1, the clock; nRST in 1, asynchronous active-low reset.
REQ-006 SHALL have these violation-event ports: viol_valid in 1; viol_ready out 1; viol_load_idx in SSIT_INDEX_WIDTH; viol_load_SSID_valid in 1; viol_load_SSID in SSID_WIDTH; viol_store_idx in SSIT_INDEX_WIDTH; viol_store_SSID_valid in 1; viol_store_SSID in SSID_WIDTH.
REQ-007 SHALL have these dispatch-touch ports: dispatch_touch_valid in 1; dispatch_touch_SSID in SSID_WIDTH.
REQ-008 SHALL have these SST ports: sst_new_SSID_valid out 1; sst_new_SSID in SSID_WIDTH, the current PLRU victim; sst_touch_SSID_valid out 1; sst_touch_SSID out SSID_WIDTH.
REQ-009 SHALL have these SSIT write ports: ssit_wr_valid out 1; ssit_wr_ready in 1; ssit_wr_index out SSIT_INDEX_WIDTH; ssit_wr_SSID out SSID_WIDTH.
REQ-010 SHALL have these status ports: busy out 1, high when the FIFO is non-empty or the FSM is not in IDLE; touch_drop_count out 8, a saturating count of dropped dispatch touches.

Function
REQ-011 SHALL push a violation event into the FIFO on viol_valid && viol_ready, with viol_ready = (count < FIFO_DEPTH), independent of a same-cycle pop.
REQ-012 SHALL run an FSM with states IDLE, WR_LOAD and WR_STORE.
REQ-013 SHALL, in IDLE with the FIFO non-empty, resolve the head event in one cycle, pop it, and latch the winner SSID plus the load/store write-needed flags.
REQ-014 SHALL resolve an event with both SSIDs invalid by asserting sst_new_SSID_valid for exactly one cycle; winner = sst_new_SSID sampled that cycle; both writes needed.
REQ-015 SHALL resolve an event with exactly one SSID valid with winner = the valid SSID, assert sst_touch_SSID_valid with that SSID, and need only the other side's write.
REQ-016 SHALL resolve an event with both SSIDs valid with winner = the numerically smaller SSID (load wins a tie), touch the winner, and need a write only on the side whose SSID differs from the winner.
REQ-017 SHALL need only the store write when load_idx == store_idx.
REQ-018 SHALL never assert sst_new_SSID_valid and sst_touch_SSID_valid in the same cycle.
REQ-019 SHALL, on leaving IDLE, go to WR_LOAD if the load write is needed, else to WR_STORE if the store write is needed, else stay in IDLE.
REQ-020 SHALL, in WR_LOAD, drive ssit_wr_valid=1, index=load_idx, SSID=winner; on ready, go to WR_STORE if the store write is needed, else to IDLE.
REQ-021 SHALL, in WR_STORE, drive ssit_wr_valid=1, index=store_idx, SSID=winner, and go to IDLE on ready.
REQ-022 SHALL hold ssit_wr_* stable while ssit_wr_valid && !ssit_wr_ready.
REQ-023 SHALL forward dispatch_touch to the SST touch port in the same cycle when the FSM is not driving either SST valid that cycle.
REQ-024 SHALL otherwise drop the dispatch touch and increment touch_drop_count, saturating at 255.
REQ-025 SHALL start the next event resolution no earlier than the cycle after returning to IDLE; throughput is at most one event per 2 cycles when no writes are needed.

Reset
REQ-026 SHALL, on nRST low, clear the FIFO, FSM=IDLE, touch_drop_count=0 and the latched winner/flags=0, asynchronously and at any point mid-operation, discarding pending writes.
REQ-027 SHALL drive these output values while in reset: viol_ready=1, sst_new_SSID_valid=0, sst_touch_SSID_valid=0, ssit_wr_valid=0, busy=0.

Structure
REQ-028 SHALL take the SSID type, the SSIT index type and the violation-event struct {load_idx, load_SSID_valid, load_SSID, store_idx, store_SSID_valid, store_SSID} from core_types_pkg.
REQ-029 SHALL instantiate one sub-module, viol_fifo, a parameterized synchronous FIFO holding the event struct.

Verification
REQ-030 SHALL cover this scenario: after reset (SST victim 0), event load_idx=0x010 and store_idx=0x020, both SSIDs invalid -> one cycle of sst_new_SSID_valid, then writes (0x010,0) and (0x020,0).
REQ-031 SHALL cover this scenario: event load SSID=5 valid, store invalid, store_idx=0x044 -> touch 5, single write (0x044,5).
REQ-032 SHALL cover this scenario: event load=9, store=3, load_idx=0x100 -> touch 3, single write (0x100,3); load=store=7 -> touch 7, no write.
REQ-033 SHALL cover this scenario: ssit_wr_ready low for 3 cycles in WR_LOAD -> outputs held stable, then WR_STORE follows.
REQ-034 SHALL cover this scenario: 5 back-to-back events with ssit_wr_ready=0 -> viol_ready=0 after the 4th push accumulates, then recovers on the first pop.
REQ-035 SHALL cover this scenario: dispatch_touch in the same cycle as resolution -> the FSM's SST access is unaffected and touch_drop_count goes 0 to 1; 300 collisions -> count stays at 255.

Source files
------------

// File: rtl/core_types_pkg.sv
// Shared types for the memory-dependence predictor: SSID, SSIT index,
// the violation event carried through the allocation FIFO, and FSM states.
package core_types_pkg;

    localparam int SSID_W     = 6;
    localparam int SSIT_IDX_W = 10;

    typedef logic [SSID_W-1:0]     ssid_t;
    typedef logic [SSIT_IDX_W-1:0] ssit_idx_t;

    typedef struct packed {
        ssit_idx_t load_idx;
        logic      load_SSID_valid;
        ssid_t     load_SSID;
        ssit_idx_t store_idx;
        logic      store_SSID_valid;
        ssid_t     store_SSID;
    } viol_event_t;

    typedef enum logic [1:0] {
        IDLE,
        WR_LOAD,
        WR_STORE
    } alloc_state_t;

endpackage

// File: rtl/viol_fifo.sv
// Small synchronous FIFO of violation events; pointers wrap at DEPTH so
// non-power-of-two depths work.
module viol_fifo
    import core_types_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        push,
    input  viol_event_t push_data,
    input  logic        pop,
    output viol_event_t head,
    output logic        empty,
    output logic        full
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    viol_event_t      mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             wr_en;
    logic             rd_en;

    function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign wr_en = push && !full;
    assign rd_en = pop && !empty;
    assign empty = (count == '0);
    assign full  = (count == CNT_W'(DEPTH));
    assign head  = mem[rd_ptr];

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) wr_ptr <= ptr_next(wr_ptr);
            if (rd_en) rd_ptr <= ptr_next(rd_ptr);
            if (wr_en && !rd_en) count <= count + 1'b1;
            else if (!wr_en && rd_en) count <= count - 1'b1;
        end
    end

    // Storage needs no reset: an empty FIFO never exposes its contents.
    always_ff @(posedge CLK) begin
        if (wr_en) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/ssid_alloc_ctrl.sv
// Store-set ID allocation: resolves buffered memory-order violations into an
// SSID winner, touches/allocates it in the SST and writes it to the SSIT.
module ssid_alloc_ctrl
    import core_types_pkg::*;
#(
    parameter int STORE_SET_COUNT  = 64,
    parameter int SSID_WIDTH       = $clog2(STORE_SET_COUNT),
    parameter int SSIT_INDEX_WIDTH = 10,
    parameter int FIFO_DEPTH       = 4
) (
    input  logic                        CLK,
    input  logic                        nRST,
    input  logic                        viol_valid,
    output logic                        viol_ready,
    input  logic [SSIT_INDEX_WIDTH-1:0] viol_load_idx,
    input  logic                        viol_load_SSID_valid,
    input  logic [SSID_WIDTH-1:0]       viol_load_SSID,
    input  logic [SSIT_INDEX_WIDTH-1:0] viol_store_idx,
    input  logic                        viol_store_SSID_valid,
    input  logic [SSID_WIDTH-1:0]       viol_store_SSID,
    input  logic                        dispatch_touch_valid,
    input  logic [SSID_WIDTH-1:0]       dispatch_touch_SSID,
    output logic                        sst_new_SSID_valid,
    input  logic [SSID_WIDTH-1:0]       sst_new_SSID,
    output logic                        sst_touch_SSID_valid,
    output logic [SSID_WIDTH-1:0]       sst_touch_SSID,
    output logic                        ssit_wr_valid,
    input  logic                        ssit_wr_ready,
    output logic [SSIT_INDEX_WIDTH-1:0] ssit_wr_index,
    output logic [SSID_WIDTH-1:0]       ssit_wr_SSID,
    output logic                        busy,
    output logic [7:0]                  touch_drop_count
);

    viol_event_t  push_evt;
    viol_event_t  head;
    logic         fifo_empty;
    logic         fifo_full;
    logic         resolve;
    logic         res_new;
    logic         res_touch;
    logic         res_need_load;
    logic         res_need_store;
    ssid_t        res_winner;
    alloc_state_t state;
    ssid_t        winner_q;
    logic         need_load_q;
    logic         need_store_q;
    ssit_idx_t    load_idx_q;
    ssit_idx_t    store_idx_q;
    logic         cooldown;
    logic         drop;

    assign push_evt = '{load_idx:         viol_load_idx,
                        load_SSID_valid:  viol_load_SSID_valid,
                        load_SSID:        viol_load_SSID,
                        store_idx:        viol_store_idx,
                        store_SSID_valid: viol_store_SSID_valid,
                        store_SSID:       viol_store_SSID};

    viol_fifo #(.DEPTH(FIFO_DEPTH)) u_viol_fifo (
        .CLK       (CLK),
        .nRST      (nRST),
        .push      (viol_valid),
        .push_data (push_evt),
        .pop       (resolve),
        .head      (head),
        .empty     (fifo_empty),
        .full      (fifo_full)
    );

    assign viol_ready = !fifo_full;

    // Cooldown keeps consecutive resolutions at least two cycles apart.
    always_comb begin
        resolve        = (state == IDLE) && !fifo_empty && !cooldown;
        res_new        = 1'b0;
        res_touch      = 1'b0;
        res_need_load  = 1'b0;
        res_need_store = 1'b0;
        res_winner     = '0;
        if (resolve) begin
            case ({head.load_SSID_valid, head.store_SSID_valid})
                2'b00: begin
                    res_new        = 1'b1;
                    res_winner     = sst_new_SSID;
                    res_need_load  = 1'b1;
                    res_need_store = 1'b1;
                end
                2'b10: begin
                    res_touch      = 1'b1;
                    res_winner     = head.load_SSID;
                    res_need_store = 1'b1;
                end
                2'b01: begin
                    res_touch      = 1'b1;
                    res_winner     = head.store_SSID;
                    res_need_load  = 1'b1;
                end
                default: begin
                    res_touch      = 1'b1;
                    res_winner     = (head.store_SSID < head.load_SSID) ? head.store_SSID : head.load_SSID;
                    res_need_load  = (head.load_SSID != res_winner);
                    res_need_store = (head.store_SSID != res_winner);
                end
            endcase
            if (head.load_idx == head.store_idx) begin
                res_need_load  = 1'b0;
                res_need_store = 1'b1;
            end
        end
    end

    assign drop                 = dispatch_touch_valid && (res_new || res_touch);
    assign sst_new_SSID_valid   = res_new;
    assign sst_touch_SSID_valid = res_touch || (nRST && dispatch_touch_valid && !res_new);
    assign sst_touch_SSID       = res_touch ? res_winner : dispatch_touch_SSID;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state        <= IDLE;
            winner_q     <= '0;
            need_load_q  <= 1'b0;
            need_store_q <= 1'b0;
            load_idx_q   <= '0;
            store_idx_q  <= '0;
            cooldown     <= 1'b0;
        end else begin
            cooldown <= resolve;
            case (state)
                IDLE: begin
                    if (resolve) begin
                        winner_q     <= res_winner;
                        need_load_q  <= res_need_load;
                        need_store_q <= res_need_store;
                        load_idx_q   <= head.load_idx;
                        store_idx_q  <= head.store_idx;
                        if (res_need_load) state <= WR_LOAD;
                        else if (res_need_store) state <= WR_STORE;
                    end
                end
                WR_LOAD: begin
                    if (ssit_wr_ready) state <= need_store_q ? WR_STORE : IDLE;
                end
                WR_STORE: begin
                    if (ssit_wr_ready) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) touch_drop_count <= 8'd0;
        else if (drop && touch_drop_count != 8'hFF) touch_drop_count <= touch_drop_count + 8'd1;
    end

    assign ssit_wr_valid = ((state == WR_LOAD) && need_load_q) || (state == WR_STORE);
    assign ssit_wr_index = (state == WR_LOAD) ? load_idx_q : store_idx_q;
    assign ssit_wr_SSID  = winner_q;
    assign busy          = !fifo_empty || (state != IDLE);

endmodule

// File: tb/tb_ssid_alloc_ctrl.sv
// Scoreboard bench for ssid_alloc_ctrl: expected SST accesses and SSIT writes
// are queued at event push and retired by a monitor as the DUT produces them.
module tb_ssid_alloc_ctrl;

    logic       CLK = 1'b0;
    logic       nRST = 1'b0;
    logic       viol_valid = 1'b0;
    logic       viol_ready;
    logic [9:0] viol_load_idx = '0;
    logic       viol_load_SSID_valid = 1'b0;
    logic [5:0] viol_load_SSID = '0;
    logic [9:0] viol_store_idx = '0;
    logic       viol_store_SSID_valid = 1'b0;
    logic [5:0] viol_store_SSID = '0;
    logic       dispatch_touch_valid = 1'b0;
    logic [5:0] dispatch_touch_SSID = 6'd63;
    logic       sst_new_SSID_valid;
    logic [5:0] sst_new_SSID = '0;
    logic       sst_touch_SSID_valid;
    logic [5:0] sst_touch_SSID;
    logic       ssit_wr_valid;
    logic       ssit_wr_ready = 1'b1;
    logic [9:0] ssit_wr_index;
    logic [5:0] ssit_wr_SSID;
    logic       busy;
    logic [7:0] touch_drop_count;

    typedef struct {logic [9:0] idx; logic [5:0] ssid;} wr_exp_t;
    typedef struct {bit is_new; logic [5:0] ssid;} sst_exp_t;

    wr_exp_t  wr_q[$];
    sst_exp_t sst_q[$];
    int       tests_run = 0;
    int       tests_failed = 0;

    ssid_alloc_ctrl dut (
        .CLK                   (CLK),
        .nRST                  (nRST),
        .viol_valid            (viol_valid),
        .viol_ready            (viol_ready),
        .viol_load_idx         (viol_load_idx),
        .viol_load_SSID_valid  (viol_load_SSID_valid),
        .viol_load_SSID        (viol_load_SSID),
        .viol_store_idx        (viol_store_idx),
        .viol_store_SSID_valid (viol_store_SSID_valid),
        .viol_store_SSID       (viol_store_SSID),
        .dispatch_touch_valid  (dispatch_touch_valid),
        .dispatch_touch_SSID   (dispatch_touch_SSID),
        .sst_new_SSID_valid    (sst_new_SSID_valid),
        .sst_new_SSID          (sst_new_SSID),
        .sst_touch_SSID_valid  (sst_touch_SSID_valid),
        .sst_touch_SSID        (sst_touch_SSID),
        .ssit_wr_valid         (ssit_wr_valid),
        .ssit_wr_ready         (ssit_wr_ready),
        .ssit_wr_index         (ssit_wr_index),
        .ssit_wr_SSID          (ssit_wr_SSID),
        .busy                  (busy),
        .touch_drop_count      (touch_drop_count)
    );

    always #5 CLK = ~CLK;

    // Monitor: retires SST accesses and SSIT write handshakes against the queues.
    always begin
        @(negedge CLK);
        #2;
        if (nRST) begin
            if (sst_new_SSID_valid && sst_touch_SSID_valid) begin
                tests_run++;
                tests_failed++;
                $display("[TB] FAIL sst_exclusive: new and touch both high");
            end
            if (sst_new_SSID_valid || sst_touch_SSID_valid) begin
                tests_run++;
                if (sst_q.size() > 0 &&
                    (sst_q[0].is_new ? sst_new_SSID_valid
                                     : (sst_touch_SSID_valid && !sst_new_SSID_valid && sst_touch_SSID == sst_q[0].ssid)))
                    void'(sst_q.pop_front());
                else if (dispatch_touch_valid && sst_touch_SSID_valid && !sst_new_SSID_valid &&
                         sst_touch_SSID == dispatch_touch_SSID) begin
                end else begin
                    tests_failed++;
                    $display("[TB] FAIL sst_access: got new=%b touch=%b ssid=%0d, expected pending=%0d",
                             sst_new_SSID_valid, sst_touch_SSID_valid, sst_touch_SSID, sst_q.size());
                end
            end else if (dispatch_touch_valid) begin
                tests_run++;
                tests_failed++;
                $display("[TB] FAIL touch_forward: got touch_valid=0, expected 1");
            end
            if (ssit_wr_valid && ssit_wr_ready) begin
                tests_run++;
                if (wr_q.size() == 0) begin
                    tests_failed++;
                    $display("[TB] FAIL ssit_write: got (%h,%0d), expected no write", ssit_wr_index, ssit_wr_SSID);
                end else begin
                    if (ssit_wr_index !== wr_q[0].idx || ssit_wr_SSID !== wr_q[0].ssid) begin
                        tests_failed++;
                        $display("[TB] FAIL ssit_write: got (%h,%0d), expected (%h,%0d)",
                                 ssit_wr_index, ssit_wr_SSID, wr_q[0].idx, wr_q[0].ssid);
                    end
                    void'(wr_q.pop_front());
                end
            end
        end
    end

    task automatic model_event(input logic [9:0] li, input logic lv, input logic [5:0] ls,
                               input logic [9:0] si, input logic sv, input logic [5:0] ss);
        logic [5:0] w;
        bit         wl;
        bit         ws;
        sst_exp_t   s;
        if (!lv && !sv) begin
            w = sst_new_SSID; wl = 1; ws = 1; s.is_new = 1;
        end else begin
            s.is_new = 0;
            if (lv && sv) begin
                w  = (ss < ls) ? ss : ls;
                wl = (ls != w);
                ws = (ss != w);
            end else if (lv) begin
                w = ls; wl = 0; ws = 1;
            end else begin
                w = ss; wl = 1; ws = 0;
            end
        end
        s.ssid = w;
        sst_q.push_back(s);
        if (li == si) begin
            wl = 0; ws = 1;
        end
        if (wl) wr_q.push_back('{idx: li, ssid: w});
        if (ws) wr_q.push_back('{idx: si, ssid: w});
    endtask

    // Called at a negedge; returns at a later negedge with viol_valid low.
    task automatic send_event(input logic [9:0] li, input logic lv, input logic [5:0] ls,
                              input logic [9:0] si, input logic sv, input logic [5:0] ss);
        bit accepted;
        accepted = 0;
        viol_load_idx = li; viol_load_SSID_valid = lv; viol_load_SSID = ls;
        viol_store_idx = si; viol_store_SSID_valid = sv; viol_store_SSID = ss;
        viol_valid = 1'b1;
        for (int t = 0; t < 200; t++) begin
            #1;
            if (viol_ready) begin
                model_event(li, lv, ls, si, sv, ss);
                accepted = 1;
                break;
            end
            @(negedge CLK);
        end
        if (!accepted) begin
            tests_run++;
            tests_failed++;
            $display("[TB] FAIL push_timeout: got viol_ready=0, expected 1 within 200 cycles");
        end
        @(negedge CLK);
        viol_valid = 1'b0;
    endtask

    task automatic drain(input string name);
        bit done;
        done = 0;
        for (int t = 0; t < 2000; t++) begin
            @(negedge CLK);
            #3;
            if (wr_q.size() == 0 && sst_q.size() == 0 && !busy) begin
                done = 1;
                break;
            end
        end
        tests_run++;
        if (!done) begin
            tests_failed++;
            $display("[TB] FAIL drain_%s: got pending wr=%0d sst=%0d busy=%b, expected all retired",
                     name, wr_q.size(), sst_q.size(), busy);
            wr_q.delete();
            sst_q.delete();
        end
        @(negedge CLK);
    endtask

    task automatic test_reset();
        dispatch_touch_valid = 1'b1;
        #2;
        tests_run++;
        if ({viol_ready, sst_new_SSID_valid, sst_touch_SSID_valid, ssit_wr_valid, busy} !== 5'b10000) begin
            tests_failed++;
            $display("[TB] FAIL reset_outputs: got ready/new/touch/wr/busy=%b, expected 10000",
                     {viol_ready, sst_new_SSID_valid, sst_touch_SSID_valid, ssit_wr_valid, busy});
        end
        tests_run++;
        if (touch_drop_count !== 8'd0) begin
            tests_failed++;
            $display("[TB] FAIL reset_drop_count: got %0d, expected 0", touch_drop_count);
        end
        dispatch_touch_valid = 1'b0;
        repeat (2) @(negedge CLK);
        nRST = 1'b1;
        @(negedge CLK);
    endtask

    task automatic test_alloc_new();
        sst_new_SSID = 6'd0;
        send_event(10'h010, 0, 6'd0, 10'h020, 0, 6'd0);
        drain("alloc_new");
    endtask

    task automatic test_single_valid();
        send_event(10'h030, 1, 6'd5, 10'h044, 0, 6'd0);
        drain("load_valid");
        send_event(10'h050, 0, 6'd0, 10'h051, 1, 6'd9);
        drain("store_valid");
        send_event(10'h055, 1, 6'd2, 10'h055, 0, 6'd0);
        drain("same_index");
    endtask

    task automatic test_both_valid();
        send_event(10'h100, 1, 6'd9, 10'h101, 1, 6'd3);
        drain("store_smaller");
        send_event(10'h110, 1, 6'd7, 10'h111, 1, 6'd7);
        drain("tie");
        send_event(10'h120, 1, 6'd4, 10'h121, 1, 6'd11);
        drain("load_smaller");
    endtask

    task automatic test_wr_stall();
        bit seen;
        seen = 0;
        sst_new_SSID = 6'd12;
        ssit_wr_ready = 1'b0;
        send_event(10'h0A0, 0, 6'd0, 10'h0B0, 0, 6'd0);
        for (int t = 0; t < 20; t++) begin
            #1;
            if (ssit_wr_valid) begin
                seen = 1;
                break;
            end
            @(negedge CLK);
        end
        tests_run++;
        if (!seen) begin
            tests_failed++;
            $display("[TB] FAIL stall_wr_valid: got 0, expected 1 within 20 cycles");
        end
        for (int c = 0; c < 3; c++) begin
            @(negedge CLK);
            #1;
            tests_run++;
            if (!ssit_wr_valid || ssit_wr_index !== 10'h0A0 || ssit_wr_SSID !== 6'd12) begin
                tests_failed++;
                $display("[TB] FAIL stall_hold: got v=%b (%h,%0d), expected v=1 (0a0,12)",
                         ssit_wr_valid, ssit_wr_index, ssit_wr_SSID);
            end
        end
        @(negedge CLK);
        ssit_wr_ready = 1'b1;
        @(negedge CLK);
        #1;
        tests_run++;
        if (!ssit_wr_valid || ssit_wr_index !== 10'h0B0) begin
            tests_failed++;
            $display("[TB] FAIL stall_then_store: got v=%b idx=%h, expected v=1 idx=0b0", ssit_wr_valid, ssit_wr_index);
        end
        drain("stall");
        sst_new_SSID = 6'd0;
    endtask

    task automatic test_back_to_back();
        bit recovered;
        recovered = 0;
        ssit_wr_ready = 1'b0;
        for (int i = 0; i < 5; i++)
            send_event(10'(10'h200 + i), 0, 6'd0, 10'(10'h300 + i), 0, 6'd0);
        for (int c = 0; c < 2; c++) begin
            #1;
            tests_run++;
            if (viol_ready !== 1'b0) begin
                tests_failed++;
                $display("[TB] FAIL full_ready: got %b, expected 0", viol_ready);
            end
            @(negedge CLK);
        end
        ssit_wr_ready = 1'b1;
        for (int t = 0; t < 10; t++) begin
            #1;
            if (viol_ready) begin
                recovered = 1;
                break;
            end
            @(negedge CLK);
        end
        tests_run++;
        if (!recovered) begin
            tests_failed++;
            $display("[TB] FAIL ready_recover: got 0, expected 1 within 10 cycles");
        end
        drain("back_to_back");
    endtask

    task automatic test_touch_drop();
        tests_run++;
        if (touch_drop_count !== 8'd0) begin
            tests_failed++;
            $display("[TB] FAIL drop_start: got %0d, expected 0", touch_drop_count);
        end
        dispatch_touch_SSID = 6'd63;
        dispatch_touch_valid = 1'b1;
        send_event(10'h060, 0, 6'd0, 10'h061, 0, 6'd0);
        drain("collide_new");
        tests_run++;
        if (touch_drop_count !== 8'd1) begin
            tests_failed++;
            $display("[TB] FAIL drop_one: got %0d, expected 1", touch_drop_count);
        end
        for (int i = 0; i < 300; i++)
            send_event(10'(i), 1, 6'd7, 10'(i + 512), 1, 6'd7);
        drain("saturate");
        tests_run++;
        if (touch_drop_count !== 8'd255) begin
            tests_failed++;
            $display("[TB] FAIL drop_saturate: got %0d, expected 255", touch_drop_count);
        end
        dispatch_touch_valid = 1'b0;
        @(negedge CLK);
    endtask

    task automatic test_reset_mid();
        ssit_wr_ready = 1'b0;
        send_event(10'h3A0, 0, 6'd0, 10'h3B0, 0, 6'd0);
        repeat (2) @(negedge CLK);
        #4;
        nRST = 1'b0;
        #1;
        tests_run++;
        if ({viol_ready, sst_new_SSID_valid, sst_touch_SSID_valid, ssit_wr_valid, busy} !== 5'b10000) begin
            tests_failed++;
            $display("[TB] FAIL mid_reset_outputs: got ready/new/touch/wr/busy=%b, expected 10000",
                     {viol_ready, sst_new_SSID_valid, sst_touch_SSID_valid, ssit_wr_valid, busy});
        end
        tests_run++;
        if (touch_drop_count !== 8'd0) begin
            tests_failed++;
            $display("[TB] FAIL mid_reset_count: got %0d, expected 0", touch_drop_count);
        end
        wr_q.delete();
        sst_q.delete();
        @(negedge CLK);
        nRST = 1'b1;
        ssit_wr_ready = 1'b1;
        repeat (3) @(negedge CLK);
        #1;
        tests_run++;
        if (ssit_wr_valid !== 1'b0 || busy !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL mid_reset_discard: got wr_valid=%b busy=%b, expected 0 0", ssit_wr_valid, busy);
        end
    endtask

    initial begin
        test_reset();
        test_alloc_new();
        test_single_valid();
        test_both_valid();
        test_wr_stall();
        test_back_to_back();
        test_touch_drop();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
